// File: rtl/abr_msg_gearbox_pkg.sv
// Shared types and helpers for the message-aware sample gearbox.
package abr_msg_gearbox_pkg;

    // Widest strobe the helpers below can take; narrower strobes are zero-extended.
    localparam int GBX_MAX_LANES = 32;

    typedef enum logic {
        GBX_ACTIVE = 1'b0,
        GBX_DRAIN  = 1'b1
    } abr_gbx_state_e;

    // Number of valid samples carried by a strobe.
    function automatic int thermo_cnt(input logic [GBX_MAX_LANES-1:0] strobe);
        int n;
        n = 0;
        for (int i = 0; i < GBX_MAX_LANES; i++) begin
            if (strobe[i]) n++;
        end
        return n;
    endfunction

    // True when strobe is contiguous from lane 0 (0, 1, 11, 111, ...).
    function automatic logic is_thermo(input logic [GBX_MAX_LANES-1:0] strobe);
        return (strobe & (strobe + 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/abr_msg_gearbox_shifter.sv
// Combinational datapath of the gearbox buffer: drop the popped entries by
// shifting the remainder down, then append the accepted write lanes directly
// above what is left.
module abr_msg_gearbox_shifter #(
    parameter int NUM_WR = 5,
    parameter int NUM_RD = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = NUM_WR + NUM_RD - 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0]  buf_data,
    input  logic [DEPTH-1:0]              buf_vld,
    input  logic [CNT_W-1:0]              popped,
    input  logic [CNT_W-1:0]              count,
    input  logic [NUM_WR-1:0]             wr_lanes,
    input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
    output logic [DEPTH-1:0][DATA_W-1:0]  next_data,
    output logic [DEPTH-1:0]              next_vld
);

    // Slot where write lane 0 lands once the pop has been applied.
    logic signed [CNT_W:0] base;

    // Shift survivors down by the pop amount, then overlay the new lanes.
    always_comb begin
        next_data = '0;
        next_vld  = '0;
        base      = $signed({1'b0, count}) - $signed({1'b0, popped});
        for (int k = 0; k <= NUM_RD; k++) begin
            if (int'(popped) == k) begin
                for (int j = 0; j < DEPTH - k; j++) begin
                    next_data[j] = buf_data[j + k];
                    next_vld[j]  = buf_vld[j + k];
                end
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_lanes[i] && (j == int'(base) + i)) begin
                    next_data[j] = wr_data[i];
                    next_vld[j]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/abr_msg_gearbox.sv
// Width-converting sample buffer between variable-rate producers (up to
// NUM_WR samples per cycle) and a fixed NUM_RD-wide consumer. A write tagged
// last switches to a drain phase that flushes the trailing partial word with
// rd_last_o before new input is taken again.
module abr_msg_gearbox
    import abr_msg_gearbox_pkg::*;
#(
    parameter int NUM_WR = 5,
    parameter int NUM_RD = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = NUM_WR + NUM_RD - 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [NUM_WR-1:0]        wr_strb_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     wr_last_i,
    output logic                     wr_ready_o,
    output logic                     rd_valid_o,
    output logic [NUM_RD-1:0]        rd_strb_o,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic                     rd_last_o,
    input  logic                     rd_ready_i,
    output logic [CNT_W-1:0]         count_o
);

    if (DEPTH < NUM_WR || DEPTH < NUM_RD) begin : g_bad_depth
        $error("abr_msg_gearbox: DEPTH must be at least NUM_WR and NUM_RD");
    end

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NUM_WR_C = CNT_W'(NUM_WR);
    localparam logic [CNT_W-1:0] NUM_RD_C = CNT_W'(NUM_RD);

    abr_gbx_state_e            state_q, state_nxt;
    logic [CNT_W-1:0]          cnt_q, cnt_nxt, popped, n_acc, free;
    logic [DEPTH-1:0]          vld_q, vld_nxt;
    logic [DEPTH*DATA_W-1:0]   data_q, data_nxt;
    logic [NUM_WR-1:0]         wr_lanes;
    logic                      wr_fire, rd_fire;

    // Handshakes and the occupancy change they cause this cycle.
    always_comb begin
        wr_fire  = (|wr_strb_i) & wr_ready_o;
        rd_fire  = rd_valid_o & rd_ready_i;
        wr_lanes = wr_fire ? wr_strb_i : '0;
        n_acc    = CNT_W'(thermo_cnt(GBX_MAX_LANES'(wr_lanes)));
        popped   = '0;
        if (rd_fire) popped = (cnt_q < NUM_RD_C) ? cnt_q : NUM_RD_C;
        cnt_nxt  = cnt_q - popped + n_acc;
        free     = DEPTH_C - cnt_q;
    end

    abr_msg_gearbox_shifter #(
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .buf_data  (data_q),
        .buf_vld   (vld_q),
        .popped    (popped),
        .count     (cnt_q),
        .wr_lanes  (wr_lanes),
        .wr_data   (wr_data_i),
        .next_data (data_nxt),
        .next_vld  (vld_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= GBX_ACTIVE;
        else     state_q <= state_nxt;
    end

    // Next state: enter drain on a last write, leave once the last word is taken.
    always_comb begin
        state_nxt = state_q;
        if (flush_i) begin
            state_nxt = GBX_ACTIVE;
        end else begin
            unique case (state_q)
                GBX_ACTIVE: if (wr_fire && wr_last_i) state_nxt = GBX_DRAIN;
                GBX_DRAIN:  if (rd_fire && rd_last_o) state_nxt = GBX_ACTIVE;
                default:    state_nxt = GBX_ACTIVE;
            endcase
        end
    end

    // Handshake outputs, decoded from registered state and occupancy only.
    always_comb begin
        wr_ready_o = 1'b0;
        rd_valid_o = 1'b0;
        rd_last_o  = 1'b0;
        unique case (state_q)
            GBX_ACTIVE: begin
                wr_ready_o = (free >= NUM_WR_C);
                rd_valid_o = (cnt_q >= NUM_RD_C);
            end
            GBX_DRAIN: begin
                rd_valid_o = (cnt_q != '0);
                rd_last_o  = (cnt_q != '0) && (cnt_q <= NUM_RD_C);
            end
            default: ;
        endcase
    end

    // Occupancy and lane valids; flush empties the buffer like reset.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            vld_q <= vld_nxt;
        end
    end

    // Sample storage; stale entries are hidden by their valid bits.
    always_ff @(posedge clk) begin
        data_q <= data_nxt;
    end

    // Output word is the bottom NUM_RD entries with invalid lanes forced to zero.
    always_comb begin
        rd_strb_o = vld_q[NUM_RD-1:0];
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (vld_q[i]) rd_data_o[i*DATA_W +: DATA_W] = data_q[i*DATA_W +: DATA_W];
        end
        count_o = cnt_q;
    end

    a_strb_thermo: assert property (@(posedge clk) disable iff (rst)
        is_thermo(GBX_MAX_LANES'(wr_strb_i)));
    a_last_needs_data: assert property (@(posedge clk) disable iff (rst)
        wr_last_i |-> (wr_strb_i != '0));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= DEPTH_C);

endmodule
